alarm_rtc: RTL and testbench



---
 rtl/alarm_rtc_pkg.sv | 35 +++
 rtl/alarm_rtc_timekeeper.sv | 72 +++++++
 rtl/alarm_rtc.sv | 175 +++++++++++++++++
 tb/tb_alarm_rtc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_rtc_pkg.sv
// Shared constants, state type and clamp helpers for the alarm_rtc peripheral.
package alarm_rtc_pkg;

    localparam logic [2:0] ADDR_STATUS     = 3'd0;
    localparam logic [2:0] ADDR_CONTROL    = 3'd1;
    localparam logic [2:0] ADDR_TIME_LO    = 3'd2;
    localparam logic [2:0] ADDR_TIME_HI    = 3'd3;
    localparam logic [2:0] ADDR_ALARM      = 3'd4;
    localparam logic [2:0] ADDR_SNOOZE_CFG = 3'd5;
    localparam logic [2:0] ADDR_RING_CFG   = 3'd6;

    localparam int unsigned CTRL_RUN      = 0;
    localparam int unsigned CTRL_ALARM_EN = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_SNOOZE   = 3;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } ring_state_t;

    function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [4:0] clamp5(input logic [4:0] v, input logic [4:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/alarm_rtc_timekeeper.sv
// Tick prescaler and hh:mm:ss counter chain with clamped software load.
module alarm_rtc_timekeeper
    import alarm_rtc_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       tick,
    input  logic       load_lo,
    input  logic       load_hi,
    input  logic [5:0] load_sec,
    input  logic [5:0] load_min,
    input  logic [4:0] load_hour,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [5:0] inc_sec,
    output logic [5:0] inc_min,
    output logic [4:0] inc_hour,
    output logic       sec_evt
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;

    assign sec_evt = run & tick & (presc == PRESC_MAX);

    always_comb begin
        inc_sec  = sec + 6'd1;
        inc_min  = min;
        inc_hour = hour;
        if (sec == SEC_MAX) begin
            inc_sec = '0;
            inc_min = min + 6'd1;
            if (min == MIN_MAX) begin
                inc_min  = '0;
                inc_hour = (hour == HOUR_MAX) ? '0 : hour + 5'd1;
            end
        end
    end

    // A software load in the same cycle as a second event drops the increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            sec   <= '0;
            min   <= '0;
            hour  <= '0;
        end else if (load_lo || load_hi) begin
            presc <= '0;
            if (load_lo) begin
                sec <= clamp6(load_sec, SEC_MAX);
                min <= clamp6(load_min, MIN_MAX);
            end
            if (load_hi) begin
                hour <= clamp5(load_hour, HOUR_MAX);
            end
        end else if (run && tick) begin
            presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
            if (sec_evt) begin
                sec  <= inc_sec;
                min  <= inc_min;
                hour <= inc_hour;
            end
        end
    end

endmodule

// File: rtl/alarm_rtc.sv
// Time-of-day / alarm peripheral: Avalon-MM register file, ring/snooze FSM, buzzer and irq.
module alarm_rtc
    import alarm_rtc_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC  = 1,
    parameter int unsigned SNOOZE_MIN_RST = 5,
    parameter int unsigned RING_SECS_RST  = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        buzzer,
    output logic        sec_pulse
);

    logic        wr, wr_status, wr_ctrl, wr_lo, wr_hi;
    logic        dismiss, snooze_stb, match, sec_evt;
    logic [2:0]  control;
    logic [5:0]  alarm_min;
    logic [4:0]  alarm_hour;
    logic [3:0]  snooze_cfg;
    logic [7:0]  ring_cfg;
    logic [5:0]  sec, min, inc_sec, inc_min;
    logic [4:0]  hour, inc_hour;
    logic        fired, fired_nxt;
    logic [7:0]  ring_cnt, ring_cnt_nxt;
    logic [9:0]  snz_cnt, snz_cnt_nxt, snz_mins, snz_load;
    logic [15:0] rd_mux;
    logic        unused_wdata;
    ring_state_t state, state_nxt;

    assign wr         = chipselect & ~write_n;
    assign wr_status  = wr & (address == ADDR_STATUS);
    assign wr_ctrl    = wr & (address == ADDR_CONTROL);
    assign wr_lo      = wr & (address == ADDR_TIME_LO);
    assign wr_hi      = wr & (address == ADDR_TIME_HI);
    assign dismiss    = wr_status;
    assign snooze_stb = wr_ctrl & writedata[CTRL_SNOOZE];
    assign unused_wdata = ^writedata[15:14];

    assign match = sec_evt & ~(wr_lo | wr_hi) & control[CTRL_ALARM_EN] &
                   (inc_sec == '0) & (inc_min == alarm_min) & (inc_hour == alarm_hour);

    assign snz_mins = (snooze_cfg == '0) ? 10'd1 : {6'd0, snooze_cfg};
    assign snz_load = snz_mins * 10'd60 - 10'd1;
    assign irq      = fired & control[CTRL_IRQ_EN];

    alarm_rtc_timekeeper #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_timekeeper (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (control[CTRL_RUN]),
        .tick      (tick),
        .load_lo   (wr_lo),
        .load_hi   (wr_hi),
        .load_sec  (writedata[5:0]),
        .load_min  (writedata[13:8]),
        .load_hour (writedata[4:0]),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .inc_sec   (inc_sec),
        .inc_min   (inc_min),
        .inc_hour  (inc_hour),
        .sec_evt   (sec_evt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            control    <= '0;
            alarm_min  <= '0;
            alarm_hour <= '0;
            snooze_cfg <= 4'(SNOOZE_MIN_RST);
            ring_cfg   <= 8'(RING_SECS_RST);
        end else if (wr) begin
            case (address)
                ADDR_CONTROL:    control    <= writedata[2:0];
                ADDR_ALARM: begin
                    alarm_min  <= clamp6(writedata[5:0], MIN_MAX);
                    alarm_hour <= clamp5(writedata[12:8], HOUR_MAX);
                end
                ADDR_SNOOZE_CFG: snooze_cfg <= writedata[3:0];
                ADDR_RING_CFG:   ring_cfg   <= writedata[7:0];
                default: ;
            endcase
        end
    end

    // Priority: dismiss, then snooze, then match/snooze expiry, then ring timeout.
    always_comb begin
        state_nxt    = state;
        fired_nxt    = fired;
        ring_cnt_nxt = ring_cnt;
        snz_cnt_nxt  = snz_cnt;
        if (dismiss) begin
            state_nxt = IDLE;
            fired_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_nxt    = RINGING;
                        fired_nxt    = 1'b1;
                        ring_cnt_nxt = ring_cfg;
                    end
                end
                RINGING: begin
                    if (snooze_stb) begin
                        state_nxt   = SNOOZE;
                        snz_cnt_nxt = snz_load;
                    end else if (match) begin
                        fired_nxt    = 1'b1;
                        ring_cnt_nxt = ring_cfg;
                    end else if (sec_evt) begin
                        if ((ring_cfg != '0) && (ring_cnt == 8'd1)) begin
                            state_nxt = IDLE;
                        end else if (ring_cnt != '0) begin
                            ring_cnt_nxt = ring_cnt - 8'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (match || (sec_evt && (snz_cnt == '0))) begin
                        state_nxt    = RINGING;
                        fired_nxt    = 1'b1;
                        ring_cnt_nxt = ring_cfg;
                    end else if (sec_evt) begin
                        snz_cnt_nxt = snz_cnt - 10'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS:     rd_mux = {13'd0, state == SNOOZE, state == RINGING, fired};
            ADDR_CONTROL:    rd_mux = {13'd0, control};
            ADDR_TIME_LO:    rd_mux = {2'd0, min, 2'd0, sec};
            ADDR_TIME_HI:    rd_mux = {11'd0, hour};
            ADDR_ALARM:      rd_mux = {3'd0, alarm_hour, 2'd0, alarm_min};
            ADDR_SNOOZE_CFG: rd_mux = {12'd0, snooze_cfg};
            ADDR_RING_CFG:   rd_mux = {8'd0, ring_cfg};
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fired     <= 1'b0;
            ring_cnt  <= '0;
            snz_cnt   <= '0;
            buzzer    <= 1'b0;
            sec_pulse <= 1'b0;
            readdata  <= '0;
        end else begin
            state     <= state_nxt;
            fired     <= fired_nxt;
            ring_cnt  <= ring_cnt_nxt;
            snz_cnt   <= snz_cnt_nxt;
            buzzer    <= (state == RINGING);
            sec_pulse <= sec_evt;
            readdata  <= rd_mux;
        end
    end

endmodule

// File: tb/tb_alarm_rtc.sv
// Self-checking bench for alarm_rtc: seconds-of-day reference model plus directed scenarios.
module tb_alarm_rtc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        irq, buzzer, sec_pulse;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    // Reference model: time as seconds since midnight, ring/snooze as remaining-seconds counts.
    int          tod = 0, ahour = 0, amin = 0, snz_cfg = 5, ring_cfg = 60;
    int          mode = 0, ring_left = 0, snz_left = 0;
    bit          run = 0, aen = 0, ien = 0, fired = 0, m_buz = 0, m_pulse = 0;
    logic [15:0] m_rd = 16'd0;

    always #5 clk = ~clk;

    alarm_rtc #(
        .TICKS_PER_SEC  (1),
        .SNOOZE_MIN_RST (5),
        .RING_SECS_RST  (60)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .buzzer     (buzzer),
        .sec_pulse  (sec_pulse)
    );

    function automatic int clampi(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [15:0] model_read(int a);
        case (a)
            0: return {13'd0, mode == M_SNZ, mode == M_RING, fired};
            1: return {13'd0, ien, aen, run};
            2: return 16'(((tod / 60) % 60) * 256 + tod % 60);
            3: return 16'(tod / 3600);
            4: return 16'(ahour * 256 + amin);
            5: return 16'(snz_cfg);
            6: return 16'(ring_cfg);
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin : model_step
        bit wr, evt, dis, snz, twr, match;
        int a, d, ntod;
        if (!reset_n) begin
            tod = 0; ahour = 0; amin = 0; snz_cfg = 5; ring_cfg = 60;
            mode = M_IDLE; ring_left = 0; snz_left = 0;
            run = 0; aen = 0; ien = 0; fired = 0;
            m_buz = 0; m_pulse = 0; m_rd = 16'd0;
        end else begin
            a   = int'(address);
            d   = int'(writedata);
            wr  = chipselect && !write_n;
            evt = run && tick;
            m_rd    = model_read(a);
            m_buz   = (mode == M_RING);
            m_pulse = evt;
            dis  = wr && (a == 0);
            snz  = wr && (a == 1) && writedata[3];
            twr  = wr && ((a == 2) || (a == 3));
            ntod = evt ? (tod + 1) % 86400 : tod;
            match = evt && !twr && aen && (ntod % 60 == 0) && (ntod / 60 == ahour * 60 + amin);
            if (dis) begin
                fired = 0;
                mode  = M_IDLE;
            end else if (snz && mode == M_RING) begin
                mode     = M_SNZ;
                snz_left = ((snz_cfg == 0) ? 1 : snz_cfg) * 60;
            end else if (match) begin
                mode = M_RING; fired = 1; ring_left = ring_cfg;
            end else if (evt && mode == M_SNZ) begin
                snz_left--;
                if (snz_left == 0) begin
                    mode = M_RING; fired = 1; ring_left = ring_cfg;
                end
            end else if (evt && mode == M_RING && ring_left > 0) begin
                ring_left--;
                if (ring_left == 0 && ring_cfg != 0) mode = M_IDLE;
            end
            if (wr) begin
                case (a)
                    1: begin run = writedata[0]; aen = writedata[1]; ien = writedata[2]; end
                    2: tod = (tod / 3600) * 3600 + clampi((d >> 8) & 63, 59) * 60 + clampi(d & 63, 59);
                    3: tod = clampi(d & 31, 23) * 3600 + tod % 3600;
                    4: begin amin = clampi(d & 63, 59); ahour = clampi((d >> 8) & 31, 23); end
                    5: snz_cfg = d & 15;
                    6: ring_cfg = d & 255;
                    default: ;
                endcase
            end
            if (!twr) tod = ntod;
        end
    end

    always @(negedge clk) begin
        chk("readdata", readdata, m_rd);
        chk("buzzer", {15'd0, buzzer}, {15'd0, m_buz});
        chk("irq", {15'd0, irq}, {15'd0, fired && ien});
        chk("sec_pulse", {15'd0, sec_pulse}, {15'd0, m_pulse});
        if (sec_pulse) pulses++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address = a;
        cyc();
        d = readdata;
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int p0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readdata", readdata, 16'h0000);
        chk("rst_buzzer", {15'd0, buzzer}, 16'd0);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_sec_pulse", {15'd0, sec_pulse}, 16'd0);
        reset_n = 1'b1;
        cyc();
        rd(3'd5, d); chk("rst_snooze_cfg", d, 16'h0005);
        rd(3'd6, d); chk("rst_ring_cfg", d, 16'h003C);
        rd(3'd2, d); chk("rst_time_lo", d, 16'h0000);
        rd(3'd1, d); chk("rst_control", d, 16'h0000);

        // 23:59:58 plus two seconds wraps to midnight
        wr(3'd2, 16'h3B3A); wr(3'd3, 16'h0017); wr(3'd1, 16'h0001);
        p0 = pulses;
        do_tick(2);
        rd(3'd2, d); chk("roll_time_lo", d, 16'h0000);
        rd(3'd3, d); chk("roll_time_hi", d, 16'h0000);
        chk("roll_pulses", 16'(pulses - p0), 16'd2);

        wr(3'd2, 16'h3F3F); rd(3'd2, d); chk("clamp_time_lo", d, 16'h3B3B);
        wr(3'd3, 16'h001F); rd(3'd3, d); chk("clamp_time_hi", d, 16'h0017);

        // alarm at 07:01, start at 07:00:59
        wr(3'd4, 16'h0701); wr(3'd2, 16'h003B); wr(3'd3, 16'h0007); wr(3'd1, 16'h0007);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("fire_irq", {15'd0, irq}, 16'd1);
        chk("fire_buzzer_lag", {15'd0, buzzer}, 16'd0);
        cyc();
        chk("fire_buzzer", {15'd0, buzzer}, 16'd1);
        rd(3'd0, d); chk("fire_status", d, 16'h0003);
        rd(3'd2, d); chk("fire_time_lo", d, 16'h0100);
        do_tick(1);

        wr(3'd5, 16'h0001); wr(3'd1, 16'h000F);
        rd(3'd0, d); chk("snooze_status", d, 16'h0005);
        chk("snooze_buzzer", {15'd0, buzzer}, 16'd0);
        rd(3'd1, d); chk("snooze_ctrl_stored", d, 16'h0007);
        do_tick(59);
        chk("snooze_hold", {15'd0, buzzer}, 16'd0);
        do_tick(1);
        chk("snooze_expire", {15'd0, buzzer}, 16'd1);
        rd(3'd0, d); chk("snooze_refire", d, 16'h0003);

        wr(3'd0, 16'h0000);
        chk("dismiss_irq", {15'd0, irq}, 16'd0);
        rd(3'd0, d); chk("dismiss_status", d, 16'h0000);
        chk("dismiss_buzzer", {15'd0, buzzer}, 16'd0);

        // ring timeout of 3 seconds
        wr(3'd6, 16'h0003); wr(3'd2, 16'h003B); wr(3'd3, 16'h0007);
        do_tick(1); chk("auto_ring", {15'd0, buzzer}, 16'd1);
        do_tick(2); chk("auto_hold", {15'd0, buzzer}, 16'd1);
        do_tick(1); chk("auto_drop", {15'd0, buzzer}, 16'd0);
        rd(3'd0, d); chk("auto_fired", d, 16'h0001);
        chk("auto_irq", {15'd0, irq}, 16'd1);
        wr(3'd0, 16'h0000);
        chk("auto_clear_irq", {15'd0, irq}, 16'd0);

        // time write in the same cycle as a second event
        chipselect = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 16'h0A14; tick = 1'b1;
        cyc();
        chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
        rd(3'd2, d); chk("collide_time_lo", d, 16'h0A14);

        // snooze_cfg 0 behaves as one minute; dismiss collides with expiry
        wr(3'd6, 16'h0000); wr(3'd5, 16'h0000); wr(3'd2, 16'h003B);
        do_tick(1); chk("cfg0_ring", {15'd0, buzzer}, 16'd1);
        wr(3'd1, 16'h000F);
        do_tick(59); chk("cfg0_hold", {15'd0, buzzer}, 16'd0);
        rd(3'd0, d); chk("cfg0_status", d, 16'h0005);
        chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 16'h0000; tick = 1'b1;
        cyc();
        chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
        cyc();
        chk("collide_dismiss_buzzer", {15'd0, buzzer}, 16'd0);
        rd(3'd0, d); chk("collide_dismiss_status", d, 16'h0000);

        // asynchronous reset while ringing
        wr(3'd6, 16'h003C); wr(3'd2, 16'h003B);
        do_tick(1); chk("pre_reset_ring", {15'd0, buzzer}, 16'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_buzzer", {15'd0, buzzer}, 16'd0);
        chk("mid_reset_irq", {15'd0, irq}, 16'd0);
        chk("mid_reset_readdata", readdata, 16'h0000);
        cyc();
        reset_n = 1'b1;
        rd(3'd2, d); chk("post_reset_time_lo", d, 16'h0000);
        rd(3'd3, d); chk("post_reset_time_hi", d, 16'h0000);
        rd(3'd5, d); chk("post_reset_snooze", d, 16'h0005);
        do_tick(3);
        chk("post_reset_quiet", {15'd0, buzzer}, 16'd0);
        rd(3'd0, d); chk("post_reset_status", d, 16'h0000);
        rd(3'd2, d); chk("post_reset_stopped", d, 16'h0000);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
